// File: rtl/aes_kat_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_kat_sequencer
// Desc     : Steps the KAT generator, launches one AES encryption per vector,
//            waits with timeout and folds each ciphertext into a signature.
//            Optional scope trigger enabled by defining AES_SEQ_TRIGGER_EN.
// Revision : 1.0 - initial release
// ============================================================================

module aes_kat_sequencer #(
    parameter int CYPHER_SIZE = 128,
    parameter int NUM_VECTORS = 128,
    parameter int TIMEOUT     = 255,
    parameter int GAP         = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    output logic                   gen_ena,
    input  logic [127:0]           gen_text,
    input  logic [CYPHER_SIZE-1:0] gen_key,
    output logic [127:0]           aes_text,
    output logic [CYPHER_SIZE-1:0] aes_key,
    output logic                   aes_start,
    input  logic                   aes_done,
    input  logic [127:0]           aes_cipher,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [7:0]             vec_count,
    output logic [127:0]           signature,
    output logic                   trig
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_GAP    = 3'd5,
        S_FINISH = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [7:0] c_num_vectors = 8'(NUM_VECTORS);
    localparam logic [8:0] c_timeout     = 9'(TIMEOUT);
    localparam logic [7:0] c_gap         = 8'(GAP);

    state_t                 r_state;
    logic                   r_gen_ena;
    logic                   r_aes_start;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;
    logic [7:0]             r_vec_count;
    logic [127:0]           r_signature;
    logic [127:0]           r_aes_text;
    logic [CYPHER_SIZE-1:0] r_aes_key;
    logic [7:0]             r_tmo_cnt;
    logic [7:0]             r_gap_cnt;
    logic                   w_tmo_hit;

    // Counter is cleared on entry to START and counts from the aes_start edge.
    assign w_tmo_hit = ({1'b0, r_tmo_cnt} + 9'd1) >= c_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_gen_ena   <= 1'b0;
            r_aes_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_vec_count <= 8'd0;
            r_signature <= 128'd0;
            r_aes_text  <= 128'd0;
            r_aes_key   <= '0;
            r_tmo_cnt   <= 8'd0;
            r_gap_cnt   <= 8'd0;
        end else begin
            r_gen_ena   <= 1'b0;
            r_aes_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state     <= S_FETCH;
                        r_gen_ena   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_vec_count <= 8'd0;
                        r_signature <= 128'd0;
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    r_aes_text  <= gen_text;
                    r_aes_key   <= gen_key;
                    r_aes_start <= 1'b1;
                    r_tmo_cnt   <= 8'd0;
                    r_state     <= S_START;
                end
                S_START: begin
                    r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (aes_done) begin
                        r_signature <= {r_signature[126:0], r_signature[127]} ^ aes_cipher;
                        r_vec_count <= r_vec_count + 8'd1;
                        r_gap_cnt   <= c_gap;
                        r_state     <= S_GAP;
                    end else if (w_tmo_hit) begin
                        r_state <= S_FAULT;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt != 8'd0) begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end else if (r_vec_count == c_num_vectors) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (!run) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state   <= S_FETCH;
                        r_gen_ena <= 1'b1;
                    end
                end
                S_FINISH: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                S_FAULT: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                        r_error <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AES_SEQ_TRIGGER_EN
    logic r_trig;

    // High from the START cycle through the WAIT cycle that ends the wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_trig <= 1'b1;
        end else if ((r_state == S_WAIT && (aes_done || w_tmo_hit)) || r_state == S_FAULT) begin
            r_trig <= 1'b0;
        end
    end

    assign trig = r_trig;
`else
    assign trig = 1'b0;
`endif

    assign gen_ena   = r_gen_ena;
    assign aes_start = r_aes_start;
    assign aes_text  = r_aes_text;
    assign aes_key   = r_aes_key;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign vec_count = r_vec_count;
    assign signature = r_signature;

endmodule

`default_nettype wire

// File: tb/tb_aes_kat_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_kat_sequencer
// Desc     : Scoreboard bench for aes_kat_sequencer with generator/core stubs.
// Revision : 1.0 - initial release
// ============================================================================

module tb_aes_kat_sequencer;

    localparam int NV = 4;
    localparam int TO = 20;
    localparam int GV = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         run = 1'b0;
    logic         gen_ena;
    logic [127:0] gen_text = '0;
    logic [127:0] gen_key = '0;
    logic [127:0] aes_text;
    logic [127:0] aes_key;
    logic         aes_start;
    logic         aes_done = 1'b0;
    logic [127:0] aes_cipher = '0;
    logic         busy;
    logic         done;
    logic         error;
    logic [7:0]   vec_count;
    logic [127:0] signature;
    logic         trig;

    aes_kat_sequencer #(
        .CYPHER_SIZE(128),
        .NUM_VECTORS(NV),
        .TIMEOUT(TO),
        .GAP(GV)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .run(run),
        .gen_ena(gen_ena),
        .gen_text(gen_text),
        .gen_key(gen_key),
        .aes_text(aes_text),
        .aes_key(aes_key),
        .aes_start(aes_start),
        .aes_done(aes_done),
        .aes_cipher(aes_cipher),
        .busy(busy),
        .done(done),
        .error(error),
        .vec_count(vec_count),
        .signature(signature),
        .trig(trig)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected data queues
    logic [255:0] exp_load[$];
    logic [135:0] exp_res[$];
    int           exp_trig[$];

    // Reference model state
    logic [127:0] m_sig = '0;
    int           m_cnt = 0;
    int           hang_at = 255;
    bit           spurious_req = 1'b0;
    int           spur_cnt = 0;
    bit           pend = 1'b0;
    int           lat_cnt = 0;
    int           cur_lat = 0;
    int           start_cyc = 0;
    int           exp_next_start = -1;

    function automatic int now_cyc();
        return int'($time / 10);
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: actual none required event", name);
    endtask

    // sel: 0 done|error, 1 vec_count==1, 2 aes_start, 3 error
    task automatic wait_sig(input int sel, input int bound, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = done | error;
                1: hit = (vec_count == 8'd1);
                2: hit = aes_start;
                default: hit = error;
            endcase
        end
        if (!hit) fail_now(name);
    endtask

    // Generator and AES core stubs; also advance the reference model
    initial begin : agents
        forever begin
            @(negedge clk);
            aes_done = 1'b0;
            if (gen_ena) begin
                gen_text = {$urandom, $urandom, $urandom, $urandom};
                gen_key  = {$urandom, $urandom, $urandom, $urandom};
                exp_load.push_back({gen_text, gen_key});
            end
            if (spur_cnt > 0) begin
                spur_cnt--;
                if (spur_cnt == 0) begin
                    aes_done   = 1'b1;
                    aes_cipher = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            if (pend) begin
                if (lat_cnt == 0) begin
                    aes_done   = 1'b1;
                    aes_cipher = {$urandom, $urandom, $urandom, $urandom};
                    pend       = 1'b0;
                    m_sig      = {m_sig[126:0], m_sig[127]} ^ aes_cipher;
                    m_cnt++;
                    exp_res.push_back({8'(m_cnt), m_sig});
                    if (spurious_req) begin
                        spur_cnt     = 2;
                        spurious_req = 1'b0;
                    end
                    if (m_cnt < NV && run)
                        exp_next_start = start_cyc + cur_lat + GV + 5;
                end else begin
                    lat_cnt--;
                end
            end
            if (aes_start) begin
                start_cyc = now_cyc();
                if (m_cnt == hang_at) begin
`ifdef AES_SEQ_TRIGGER_EN
                    exp_trig.push_back(TO);
`endif
                end else begin
                    cur_lat = int'($urandom_range(1, 8));
                    lat_cnt = cur_lat;
                    pend    = 1'b1;
`ifdef AES_SEQ_TRIGGER_EN
                    exp_trig.push_back(cur_lat + 2);
`endif
                end
            end
        end
    end

    // Monitor: compares whatever the DUT presents against queued expectations
    initial begin : monitor
        logic [7:0]   last_vc;
        logic [255:0] el;
        logic [135:0] er;
        int           trig_len;
        last_vc  = 8'd0;
        trig_len = 0;
        forever begin
            @(negedge clk);
            if (aes_start) begin
                if (exp_load.size() == 0) begin
                    fail_now("load_unexpected");
                end else begin
                    el = exp_load.pop_front();
                    check("aes_text", {128'd0, aes_text}, {128'd0, el[255:128]});
                    check("aes_key", {128'd0, aes_key}, {128'd0, el[127:0]});
                end
                if (exp_next_start >= 0) begin
                    check("vector_period", 256'(now_cyc()), 256'(exp_next_start));
                    exp_next_start = -1;
                end
            end
            if (vec_count != last_vc && vec_count != 8'd0) begin
                if (exp_res.size() == 0) begin
                    fail_now("result_unexpected");
                end else begin
                    er = exp_res.pop_front();
                    check("vec_count", 256'(vec_count), 256'(er[135:128]));
                    check("signature", {128'd0, signature}, {128'd0, er[127:0]});
                end
            end
            last_vc = vec_count;
`ifdef AES_SEQ_TRIGGER_EN
            if (trig) begin
                trig_len++;
            end else if (trig_len > 0) begin
                if (exp_trig.size() == 0) fail_now("trig_unexpected");
                else check("trig_len", 256'(trig_len), 256'(exp_trig.pop_front()));
                trig_len = 0;
            end
`endif
        end
    end

    task automatic start_sweep();
        m_sig = '0;
        m_cnt = 0;
        exp_next_start = -1;
        run = 1'b1;
    endtask

    initial begin : main
        // Reset with run asserted: everything held at zero
        run = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_gen_ena", 256'(gen_ena), 256'(0));
        check("rst_aes_start", 256'(aes_start), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_error", 256'(error), 256'(0));
        check("rst_vec_count", 256'(vec_count), 256'(0));
        check("rst_signature", {128'd0, signature}, 256'(0));
        check("rst_aes_text", {128'd0, aes_text}, 256'(0));
        check("rst_trig", 256'(trig), 256'(0));

        // Sweep 1: release reset, gen_ena must follow one edge later
        m_sig = '0;
        m_cnt = 0;
        reset_n = 1'b1;
        @(negedge clk);
        check("first_gen_ena", 256'(gen_ena), 256'(1));
        check("first_busy", 256'(busy), 256'(1));
        wait_sig(0, 400, "sweep1_timeout");
        check("s1_done", 256'(done), 256'(1));
        check("s1_error", 256'(error), 256'(0));
        check("s1_busy", 256'(busy), 256'(0));
        check("s1_vec_count", 256'(vec_count), 256'(NV));
        check("s1_signature", {128'd0, signature}, {128'd0, m_sig});
        check("s1_trig", 256'(trig), 256'(0));
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("s1_done_clear", 256'(done), 256'(0));

        // Sweep 2: new random latencies and ciphers
        start_sweep();
        wait_sig(0, 400, "sweep2_timeout");
        check("s2_done", 256'(done), 256'(1));
        check("s2_vec_count", 256'(vec_count), 256'(NV));
        check("s2_signature", {128'd0, signature}, {128'd0, m_sig});
        run = 1'b0;
        repeat (2) @(negedge clk);

        // Abort during second WAIT, with a spurious done in the following GAP
        start_sweep();
        wait_sig(1, 200, "abort_vc1_timeout");
        wait_sig(2, 50, "abort_start2_timeout");
        run = 1'b0;
        spurious_req = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_vec_count", 256'(vec_count), 256'(2));
        check("abort_done", 256'(done), 256'(0));
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_error", 256'(error), 256'(0));
        check("abort_signature", {128'd0, signature}, {128'd0, m_sig});
        check("abort_no_fetch", 256'(exp_load.size()), 256'(0));

        // Timeout on the second vector of a sweep
        hang_at = 1;
        start_sweep();
        wait_sig(3, 300, "fault_timeout");
        check("fault_latency", 256'(now_cyc() - start_cyc), 256'(TO));
        check("fault_error", 256'(error), 256'(1));
        check("fault_busy", 256'(busy), 256'(0));
        check("fault_done", 256'(done), 256'(0));
        repeat (5) @(negedge clk);
        check("fault_vec_frozen", 256'(vec_count), 256'(1));
        check("fault_sig_frozen", {128'd0, signature}, {128'd0, m_sig});
        check("fault_trig", 256'(trig), 256'(0));
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("fault_error_clear", 256'(error), 256'(0));
        check("fault_idle_busy", 256'(busy), 256'(0));
        hang_at = 255;

        repeat (5) @(negedge clk);
        check("res_queue_empty", 256'(exp_res.size()), 256'(0));
        check("trig_queue_empty", 256'(exp_trig.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual hung required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
